hpu_alu_disp: RTL and testbench
===============================

Name: hpu_alu_disp

Overview:
- Dispatch-side producer for the ALU issue queues. It accepts renamed ALU instructions from the rename stage into a small in-order buffer.
- It keeps a physical-register ready table (READY/FLY) that allocations and awake broadcasts update. Each buffered instruction is sent with its source-ready status.
- It steers each instruction to ALU IQ 0 or ALU IQ 1 through the IQ insert handshake (avail & vld & rdy), and it honours flush and checkpoint recovery.

Parameters:
- BUF_LEN, 2, dispatch buffer depth in entries (power of two).
- PRF_LEN, 64, number of physical registers tracked by the ready table.
- PRF_INDEX, 6, log2(PRF_LEN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_en_i  in  1  pipeline flush
- ckpt_rcov_i  in  update_ckpt_t  checkpoint recovery: .en, .ckpt
- id__prefet_ckpt_i  in  ckpt_t  prefetch checkpoint passed to chk_ckpt
- rn_disp__inst_i  in  alu_inst_t  renamed instruction
- rn_disp__inst_vld_i  in  1  instruction valid
- disp_rn__inst_rdy_o  out  1  buffer can accept
- id_alu__inst_o  out  alu_inst_t  instruction to both IQs
- id_alu__inst_vld_o  out  1  head valid
- id_alu0__avail_o  out  1  head targets IQ0
- id_alu1__avail_o  out  1  head targets IQ1
- id_alu__rs1_ready_o  out  sr_status_e  rs1 status of head
- id_alu__rs2_ready_o  out  sr_status_e  rs2 status of head
- alu0_id__inst_rdy_i  in  1  IQ0 not full
- alu1_id__inst_rdy_i  in  1  IQ1 not full
- alu0_id__left_size_i  in  ALU_IQ_INDEX+1  IQ0 free entries
- alu1_id__left_size_i  in  ALU_IQ_INDEX+1  IQ1 free entries
- alu0_iq__awake_i, alu1_iq__awake_i, mdu_iq__awake_i, lsu_iq__awake_i  in  awake_index_t  wakeup broadcasts

Behaviour:
- Reset (rst_i=1 at clk edge):
  - buffer empty; count=0; head=tail=0.
  - all table entries READY.
  - outputs: vld=0, avail0=avail1=0, inst_o=0, rdy_o=1.
- Push: when rn_disp__inst_vld_i & disp_rn__inst_rdy_o, write to the tail and advance the tail (wrap mod BUF_LEN).
  - disp_rn__inst_rdy_o = (count<BUF_LEN) & !flush_en_i. There is no combinational path from IQ rdy.
- Head presentation: id_alu__inst_o = buf[head]; id_alu__inst_vld_o = (count!=0).
  - A push at edge N is visible at the head no earlier than cycle N+1.
- Steering is combinational on the head:
  - prefer the IQ with the larger left_size; on a tie, IQ0.
  - if the preferred IQ rdy=0 and the other rdy=1, use the other.
  - if both rdy=0, no avail is asserted.
  - avail0/avail1 are never both 1. Both are 0 when the buffer is empty.
- Pop: fires when vld & ((avail0&alu0_rdy) | (avail1&alu1_rdy)) & !flush_en_i & !ckpt_rcov_i.en. The head then advances.
  - Push and pop in the same cycle leave count unchanged.
- Source ready outputs:
  - rsX_ready_o = table[head.phy_rsX_index].
  - Physical index 0 always reads READY.
  - Same-cycle awake matches are not bypassed here; the IQ resolves them at insertion.
- Ready table update at each edge:
  - every awake_i with .en=1 sets table[rdst_index]=READY.
  - on pop with opcode.rdst_en=1 and phy_rdst_index!=0, table[phy_rdst_index]=FLY.
  - an allocation (FLY) beats an awake (READY) to the same index in the same cycle.
- Flush (priority over everything):
  - next state: buffer empty, count=0, all table entries READY.
  - no pop; the push is ignored.
- Checkpoint recovery (ckpt_rcov_i.en=1, no flush):
  - scan from the head toward the tail; the first entry e with chk_ckpt(e.ckpt, ckpt_rcov_i.ckpt, id__prefet_ckpt_i) true, and every entry after it, is discarded (tail := that position, count reduced).
  - no pop this cycle; an incoming push is still accepted and is appended after the truncation.
  - the ready table is unchanged.
- Wrap-around: head/tail are PRF-independent log2(BUF_LEN)-bit pointers. count is a separate log2(BUF_LEN)+1-bit counter.

Test Plan:
- Reset, then push inst A (rs1=5, rs2=0, rdst=9, rdst_en=1) with left_size0=4, left_size1=6, both rdy=1 -> cycle+1: vld=1, avail1=1, avail0=0, rs1=READY, rs2=READY; after pop table[9]=FLY.
- Push B with rs1=9 after A pops, no awake -> rs1_ready_o=FLY. Then assert alu0 awake en=1, index 9 -> next cycle rs1_ready_o=READY.
- left_size0=left_size1=3, alu0 rdy=0, alu1 rdy=1 -> avail1=1. Both rdy=0 -> no avail, no pop, count holds at 2, rdy_o=0.
- Buffer full (2 entries, ckpt 1 then 2); ckpt_rcov en with ckpt matching entry 1 only -> both discarded (entry 2 is younger); count=0 next cycle; no avail/pop that cycle.
- Flush while full, with a push valid and awake pending -> next cycle count=0, vld=0, rdy_o=1, every table index READY.
- Same-cycle pop allocating rdst=12 and lsu awake index 12 -> table[12]=FLY.

Source files
------------

// File: rtl/hpu_alu_disp.sv
// hpu_alu_disp: dispatch buffer feeding the two ALU issue queues.
// Holds renamed ALU instructions in order, tracks physical-register readiness,
// steers the head instruction to the emptier ready IQ and handles flush and
// checkpoint recovery.

package hpu_alu_disp_pkg;

   localparam int HPU_PRF_INDEX    = 6;
   localparam int HPU_ALU_IQ_INDEX = 3;
   localparam int HPU_CKPT_INDEX   = 3;

   typedef logic [HPU_CKPT_INDEX-1:0] ckpt_t;

   typedef struct packed {
      logic  en;
      ckpt_t ckpt;
   } update_ckpt_t;

   typedef enum logic {
      SR_FLY   = 1'b0,
      SR_READY = 1'b1
   } sr_status_e;

   typedef struct packed {
      logic                     en;
      logic [HPU_PRF_INDEX-1:0] rdst_index;
   } awake_index_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       rdst_en;
   } alu_opcode_t;

   typedef struct packed {
      alu_opcode_t              opcode;
      logic [HPU_PRF_INDEX-1:0] phy_rs1_index;
      logic [HPU_PRF_INDEX-1:0] phy_rs2_index;
      logic [HPU_PRF_INDEX-1:0] phy_rdst_index;
      ckpt_t                    ckpt;
      logic [31:0]              imm;
      logic [31:0]              pc;
   } alu_inst_t;

   // True when inst_ckpt lies in the circular window that starts at the
   // recovered checkpoint and ends at the newest (prefetch) checkpoint, i.e.
   // the instruction was renamed on or after the mispredicted branch.
   function automatic logic chk_ckpt(ckpt_t inst_ckpt, ckpt_t rcov_ckpt, ckpt_t prefet_ckpt);
      ckpt_t dist_inst;
      ckpt_t dist_pref;
      dist_inst = inst_ckpt - rcov_ckpt;
      dist_pref = prefet_ckpt - rcov_ckpt;
      return dist_inst <= dist_pref;
   endfunction

endpackage

module hpu_alu_disp
   import hpu_alu_disp_pkg::*;
#(
   parameter int BUF_LEN   = 2,
   parameter int PRF_LEN   = 64,
   parameter int PRF_INDEX = 6
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_en_i,
   input  update_ckpt_t                ckpt_rcov_i,
   input  ckpt_t                       id__prefet_ckpt_i,
   input  alu_inst_t                   rn_disp__inst_i,
   input  logic                        rn_disp__inst_vld_i,
   output logic                        disp_rn__inst_rdy_o,
   output alu_inst_t                   id_alu__inst_o,
   output logic                        id_alu__inst_vld_o,
   output logic                        id_alu0__avail_o,
   output logic                        id_alu1__avail_o,
   output sr_status_e                  id_alu__rs1_ready_o,
   output sr_status_e                  id_alu__rs2_ready_o,
   input  logic                        alu0_id__inst_rdy_i,
   input  logic                        alu1_id__inst_rdy_i,
   input  logic [HPU_ALU_IQ_INDEX:0]   alu0_id__left_size_i,
   input  logic [HPU_ALU_IQ_INDEX:0]   alu1_id__left_size_i,
   input  awake_index_t                alu0_iq__awake_i,
   input  awake_index_t                alu1_iq__awake_i,
   input  awake_index_t                mdu_iq__awake_i,
   input  awake_index_t                lsu_iq__awake_i
);

   localparam int PTR_W = $clog2(BUF_LEN);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] BUF_LEN_C = CNT_W'(BUF_LEN);
   localparam int N_AWAKE = 4;

   // Instruction storage and pointers.
   alu_inst_t          inst_buf_reg [BUF_LEN];
   logic [PTR_W-1:0]   head_reg, head_next;
   logic [PTR_W-1:0]   tail_reg, tail_next;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count_reg, count_next;

   // One bit per physical register, 1 = value still in flight.
   logic [PRF_LEN-1:0] fly_reg, fly_next;

   alu_inst_t          head_inst;
   logic               head_vld;
   logic               push_fire;
   logic               pop_fire;
   logic               avail0;
   logic               avail1;
   logic [PRF_INDEX-1:0] rs1_idx;
   logic [PRF_INDEX-1:0] rs2_idx;
   logic [PRF_INDEX-1:0] rdst_idx;

   logic [BUF_LEN-1:0] hit_vec;
   logic               trunc_hit;
   logic [CNT_W-1:0]   trunc_off;

   awake_index_t       awake_vec [N_AWAKE];

   assign awake_vec[0] = alu0_iq__awake_i;
   assign awake_vec[1] = alu1_iq__awake_i;
   assign awake_vec[2] = mdu_iq__awake_i;
   assign awake_vec[3] = lsu_iq__awake_i;

   // ------------------------------------------------------------------
   // Head presentation and handshakes
   // ------------------------------------------------------------------
   assign head_inst           = inst_buf_reg[head_reg];
   assign head_vld            = (count_reg != '0);
   assign id_alu__inst_o      = head_inst;
   assign id_alu__inst_vld_o  = head_vld;
   assign id_alu0__avail_o    = avail0;
   assign id_alu1__avail_o    = avail1;

   // Acceptance depends only on local occupancy, never on IQ readiness.
   assign disp_rn__inst_rdy_o = (count_reg < BUF_LEN_C) && !flush_en_i;
   assign push_fire           = rn_disp__inst_vld_i && disp_rn__inst_rdy_o;

   // avail is already qualified by vld, flush and recovery, so the IQ
   // handshake and the local pop always agree.
   assign pop_fire = (avail0 && alu0_id__inst_rdy_i) || (avail1 && alu1_id__inst_rdy_i);

   // Source readiness straight from the table; p0 is hardwired ready.
   assign rs1_idx  = head_inst.phy_rs1_index;
   assign rs2_idx  = head_inst.phy_rs2_index;
   assign rdst_idx = head_inst.phy_rdst_index;

   assign id_alu__rs1_ready_o = ((rs1_idx == '0) || !fly_reg[rs1_idx]) ? SR_READY : SR_FLY;
   assign id_alu__rs2_ready_o = ((rs2_idx == '0) || !fly_reg[rs2_idx]) ? SR_READY : SR_FLY;

   // Steering: emptier IQ first (IQ0 on a tie), fall back to the other if
   // the preferred one is full; nothing offered during flush or recovery.
   always_comb begin
      avail0 = 1'b0;
      avail1 = 1'b0;
      if (head_vld && !flush_en_i && !ckpt_rcov_i.en) begin
         if (alu1_id__left_size_i > alu0_id__left_size_i) begin
            if (alu1_id__inst_rdy_i)      avail1 = 1'b1;
            else if (alu0_id__inst_rdy_i) avail0 = 1'b1;
         end else begin
            if (alu0_id__inst_rdy_i)      avail0 = 1'b1;
            else if (alu1_id__inst_rdy_i) avail1 = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Checkpoint recovery scan: one comparator per buffer slot, ordered
   // by age starting at the head.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < BUF_LEN; gi++) begin : g_scan
         logic [PTR_W-1:0] pos;
         assign pos = head_reg + PTR_W'(gi);
         assign hit_vec[gi] = (CNT_W'(gi) < count_reg) &&
                              chk_ckpt(inst_buf_reg[pos].ckpt, ckpt_rcov_i.ckpt, id__prefet_ckpt_i);
      end
   endgenerate

   // Oldest matching slot wins; everything from it onward is dropped.
   always_comb begin
      trunc_hit = 1'b0;
      trunc_off = '0;
      for (int k = BUF_LEN - 1; k >= 0; k--) begin
         if (hit_vec[k]) begin
            trunc_hit = 1'b1;
            trunc_off = CNT_W'(k);
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state for pointers, count and the ready table.
   // ------------------------------------------------------------------
   // Flush clears everything; otherwise recovery truncates the tail first,
   // then push/pop/awake/allocate are applied on top.
   always_comb begin
      logic [PTR_W-1:0] base_tail;
      logic [CNT_W-1:0] base_count;

      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      fly_next   = fly_reg;
      wr_ptr     = tail_reg;
      base_tail  = tail_reg;
      base_count = count_reg;

      if (flush_en_i) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
         fly_next   = '0;
      end else begin
         if (ckpt_rcov_i.en && trunc_hit) begin
            base_tail  = head_reg + trunc_off[PTR_W-1:0];
            base_count = trunc_off;
         end

         wr_ptr     = base_tail;
         tail_next  = push_fire ? base_tail + PTR_W'(1) : base_tail;
         head_next  = pop_fire ? head_reg + PTR_W'(1) : head_reg;
         count_next = base_count + CNT_W'(push_fire) - CNT_W'(pop_fire);

         // Wakeups first so a same-cycle allocation to that index wins.
         for (int i = 0; i < N_AWAKE; i++) begin
            if (awake_vec[i].en) fly_next[awake_vec[i].rdst_index] = 1'b0;
         end
         if (pop_fire && head_inst.opcode.rdst_en && (rdst_idx != '0)) begin
            fly_next[rdst_idx] = 1'b1;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         fly_reg   <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         fly_reg   <= fly_next;
      end
   end

   // Instruction storage: cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BUF_LEN; i++) inst_buf_reg[i] <= '0;
      end else if (push_fire) begin
         inst_buf_reg[wr_ptr] <= rn_disp__inst_i;
      end
   end

endmodule

// File: tb/tb_hpu_alu_disp.sv
// Directed bench for hpu_alu_disp: steering, ready table, flush, recovery.
module tb_hpu_alu_disp;
   import hpu_alu_disp_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_en_i;
   update_ckpt_t ckpt_rcov_i;
   ckpt_t        id__prefet_ckpt_i;
   alu_inst_t    rn_disp__inst_i;
   logic         rn_disp__inst_vld_i;
   logic         disp_rn__inst_rdy_o;
   alu_inst_t    id_alu__inst_o;
   logic         id_alu__inst_vld_o;
   logic         id_alu0__avail_o;
   logic         id_alu1__avail_o;
   sr_status_e   id_alu__rs1_ready_o;
   sr_status_e   id_alu__rs2_ready_o;
   logic         alu0_id__inst_rdy_i;
   logic         alu1_id__inst_rdy_i;
   logic [HPU_ALU_IQ_INDEX:0] alu0_id__left_size_i;
   logic [HPU_ALU_IQ_INDEX:0] alu1_id__left_size_i;
   awake_index_t alu0_iq__awake_i;
   awake_index_t alu1_iq__awake_i;
   awake_index_t mdu_iq__awake_i;
   awake_index_t lsu_iq__awake_i;

   int vectors     = 0;
   int miscompares = 0;

   alu_inst_t inst_a, inst_b, inst_c, inst_e, inst_f, inst_g, inst_h, inst_i, inst_j, inst_k;

   always #5 clk_i = ~clk_i;

   hpu_alu_disp dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .flush_en_i           (flush_en_i),
      .ckpt_rcov_i          (ckpt_rcov_i),
      .id__prefet_ckpt_i    (id__prefet_ckpt_i),
      .rn_disp__inst_i      (rn_disp__inst_i),
      .rn_disp__inst_vld_i  (rn_disp__inst_vld_i),
      .disp_rn__inst_rdy_o  (disp_rn__inst_rdy_o),
      .id_alu__inst_o       (id_alu__inst_o),
      .id_alu__inst_vld_o   (id_alu__inst_vld_o),
      .id_alu0__avail_o     (id_alu0__avail_o),
      .id_alu1__avail_o     (id_alu1__avail_o),
      .id_alu__rs1_ready_o  (id_alu__rs1_ready_o),
      .id_alu__rs2_ready_o  (id_alu__rs2_ready_o),
      .alu0_id__inst_rdy_i  (alu0_id__inst_rdy_i),
      .alu1_id__inst_rdy_i  (alu1_id__inst_rdy_i),
      .alu0_id__left_size_i (alu0_id__left_size_i),
      .alu1_id__left_size_i (alu1_id__left_size_i),
      .alu0_iq__awake_i     (alu0_iq__awake_i),
      .alu1_iq__awake_i     (alu1_iq__awake_i),
      .mdu_iq__awake_i      (mdu_iq__awake_i),
      .lsu_iq__awake_i      (lsu_iq__awake_i)
   );

   function automatic alu_inst_t mk(input int rs1, input int rs2, input int rdst,
                                    input logic rdst_en, input int ckpt, input int pc);
      alu_inst_t t;
      t = '0;
      t.opcode.alu_op   = 4'h3;
      t.opcode.rdst_en  = rdst_en;
      t.phy_rs1_index   = 6'(rs1);
      t.phy_rs2_index   = 6'(rs2);
      t.phy_rdst_index  = 6'(rdst);
      t.ckpt            = ckpt_t'(ckpt);
      t.imm             = 32'h0000_1000 + 32'(pc);
      t.pc              = 32'h8000_0000 + 32'(pc * 4);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b want 0", id_alu__inst_vld_o); end
      vectors++; if (id_alu0__avail_o !== 1'b0) begin miscompares++; $display("FAIL reset_avail0: got %b want 0", id_alu0__avail_o); end
      vectors++; if (id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL reset_avail1: got %b want 0", id_alu1__avail_o); end
      vectors++; if (id_alu__inst_o !== alu_inst_t'('0)) begin miscompares++; $display("FAIL reset_inst: got %h want 0", id_alu__inst_o); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b want 1", disp_rn__inst_rdy_o); end
      $display("test_reset done");
   endtask

   task automatic test_steer_pop();
      alu0_id__left_size_i = 4'd4;
      alu1_id__left_size_i = 4'd6;
      alu0_id__inst_rdy_i  = 1'b1;
      alu1_id__inst_rdy_i  = 1'b1;
      rn_disp__inst_i      = inst_a;
      rn_disp__inst_vld_i  = 1'b1;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL a_not_yet_vld: got %b want 0", id_alu__inst_vld_o); end
      tick();
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b1) begin miscompares++; $display("FAIL a_vld: got %b want 1", id_alu__inst_vld_o); end
      vectors++; if (id_alu1__avail_o !== 1'b1) begin miscompares++; $display("FAIL a_avail1: got %b want 1", id_alu1__avail_o); end
      vectors++; if (id_alu0__avail_o !== 1'b0) begin miscompares++; $display("FAIL a_avail0: got %b want 0", id_alu0__avail_o); end
      vectors++; if (id_alu__rs1_ready_o !== SR_READY) begin miscompares++; $display("FAIL a_rs1: got %0d want %0d", id_alu__rs1_ready_o, SR_READY); end
      vectors++; if (id_alu__rs2_ready_o !== SR_READY) begin miscompares++; $display("FAIL a_rs2: got %0d want %0d", id_alu__rs2_ready_o, SR_READY); end
      vectors++; if (id_alu__inst_o !== inst_a) begin miscompares++; $display("FAIL a_inst: got %h want %h", id_alu__inst_o, inst_a); end
      tick();
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL a_popped: got %b want 0", id_alu__inst_vld_o); end
      $display("test_steer_pop done");
   endtask

   task automatic test_wakeup();
      alu0_id__inst_rdy_i = 1'b0;
      alu1_id__inst_rdy_i = 1'b0;
      rn_disp__inst_i     = inst_b;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (id_alu__rs1_ready_o !== SR_FLY) begin miscompares++; $display("FAIL b_rs1_fly: got %0d want %0d", id_alu__rs1_ready_o, SR_FLY); end
      vectors++; if (id_alu0__avail_o !== 1'b0 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL b_no_avail: got %b%b want 00", id_alu0__avail_o, id_alu1__avail_o); end
      alu0_iq__awake_i = '{en: 1'b1, rdst_index: 6'd9};
      #1;
      vectors++; if (id_alu__rs1_ready_o !== SR_FLY) begin miscompares++; $display("FAIL b_no_bypass: got %0d want %0d", id_alu__rs1_ready_o, SR_FLY); end
      tick();
      alu0_iq__awake_i = '0;
      #1;
      vectors++; if (id_alu__rs1_ready_o !== SR_READY) begin miscompares++; $display("FAIL b_rs1_woken: got %0d want %0d", id_alu__rs1_ready_o, SR_READY); end
      $display("test_wakeup done");
   endtask

   task automatic test_steer_select();
      rn_disp__inst_i     = inst_c;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (disp_rn__inst_rdy_o !== 1'b0) begin miscompares++; $display("FAIL full_rdy: got %b want 0", disp_rn__inst_rdy_o); end
      tick();
      #1;
      vectors++; if (id_alu__inst_o !== inst_b) begin miscompares++; $display("FAIL hold_head: got %h want %h", id_alu__inst_o, inst_b); end
      vectors++; if (id_alu0__avail_o !== 1'b0 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL both_busy_avail: got %b%b want 00", id_alu0__avail_o, id_alu1__avail_o); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b0) begin miscompares++; $display("FAIL hold_rdy: got %b want 0", disp_rn__inst_rdy_o); end
      alu0_id__left_size_i = 4'd3;
      alu1_id__left_size_i = 4'd3;
      alu1_id__inst_rdy_i  = 1'b1;
      #1;
      vectors++; if (id_alu1__avail_o !== 1'b1 || id_alu0__avail_o !== 1'b0) begin miscompares++; $display("FAIL tie_iq0_busy: got %b%b want 01", id_alu0__avail_o, id_alu1__avail_o); end
      alu0_id__left_size_i = 4'd2;
      alu1_id__left_size_i = 4'd7;
      alu0_id__inst_rdy_i  = 1'b1;
      alu1_id__inst_rdy_i  = 1'b0;
      #1;
      vectors++; if (id_alu0__avail_o !== 1'b1 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL pref1_fallback0: got %b%b want 10", id_alu0__avail_o, id_alu1__avail_o); end
      alu0_id__left_size_i = 4'd7;
      alu1_id__left_size_i = 4'd2;
      alu1_id__inst_rdy_i  = 1'b1;
      #1;
      vectors++; if (id_alu0__avail_o !== 1'b1 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL pref0: got %b%b want 10", id_alu0__avail_o, id_alu1__avail_o); end
      alu0_id__left_size_i = 4'd3;
      alu1_id__left_size_i = 4'd3;
      #1;
      vectors++; if (id_alu0__avail_o !== 1'b1 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL tie_both_rdy: got %b%b want 10", id_alu0__avail_o, id_alu1__avail_o); end
      tick();
      #1;
      vectors++; if (id_alu__inst_o !== inst_c) begin miscompares++; $display("FAIL pop_b_head: got %h want %h", id_alu__inst_o, inst_c); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b1) begin miscompares++; $display("FAIL pop_b_rdy: got %b want 1", disp_rn__inst_rdy_o); end
      $display("test_steer_select done");
   endtask

   task automatic test_alloc_vs_awake();
      lsu_iq__awake_i = '{en: 1'b1, rdst_index: 6'd12};
      tick();
      lsu_iq__awake_i     = '0;
      alu0_id__inst_rdy_i = 1'b0;
      alu1_id__inst_rdy_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL c_popped: got %b want 0", id_alu__inst_vld_o); end
      rn_disp__inst_i     = inst_e;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (id_alu__rs1_ready_o !== SR_READY) begin miscompares++; $display("FAIL e_rs1_9: got %0d want %0d", id_alu__rs1_ready_o, SR_READY); end
      vectors++; if (id_alu__rs2_ready_o !== SR_FLY) begin miscompares++; $display("FAIL e_rs2_12_alloc_wins: got %0d want %0d", id_alu__rs2_ready_o, SR_FLY); end
      $display("test_alloc_vs_awake done");
   endtask

   task automatic test_flush();
      rn_disp__inst_i     = inst_f;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_i     = inst_k;
      flush_en_i          = 1'b1;
      alu1_iq__awake_i    = '{en: 1'b1, rdst_index: 6'd40};
      alu0_id__inst_rdy_i = 1'b1;
      alu1_id__inst_rdy_i = 1'b1;
      #1;
      vectors++; if (disp_rn__inst_rdy_o !== 1'b0) begin miscompares++; $display("FAIL flush_rdy_low: got %b want 0", disp_rn__inst_rdy_o); end
      vectors++; if (id_alu0__avail_o !== 1'b0 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL flush_avail: got %b%b want 00", id_alu0__avail_o, id_alu1__avail_o); end
      tick();
      flush_en_i          = 1'b0;
      rn_disp__inst_vld_i = 1'b0;
      alu1_iq__awake_i    = '0;
      alu0_id__inst_rdy_i = 1'b0;
      alu1_id__inst_rdy_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL flush_vld: got %b want 0", id_alu__inst_vld_o); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b1) begin miscompares++; $display("FAIL flush_rdy: got %b want 1", disp_rn__inst_rdy_o); end
      rn_disp__inst_i     = inst_g;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_o !== inst_g) begin miscompares++; $display("FAIL flush_push_ignored: got %h want %h", id_alu__inst_o, inst_g); end
      vectors++; if (id_alu__rs1_ready_o !== SR_READY) begin miscompares++; $display("FAIL flush_tbl_12: got %0d want %0d", id_alu__rs1_ready_o, SR_READY); end
      vectors++; if (id_alu__rs2_ready_o !== SR_READY) begin miscompares++; $display("FAIL flush_tbl_9: got %0d want %0d", id_alu__rs2_ready_o, SR_READY); end
      $display("test_flush done");
   endtask

   task automatic test_ckpt_rcov();
      flush_en_i = 1'b1;
      tick();
      flush_en_i          = 1'b0;
      id__prefet_ckpt_i   = 3'd3;
      rn_disp__inst_i     = inst_h;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_i = inst_i;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      ckpt_rcov_i         = '{en: 1'b1, ckpt: 3'd1};
      alu0_id__inst_rdy_i = 1'b1;
      alu1_id__inst_rdy_i = 1'b1;
      #1;
      vectors++; if (id_alu0__avail_o !== 1'b0 || id_alu1__avail_o !== 1'b0) begin miscompares++; $display("FAIL rcov_avail: got %b%b want 00", id_alu0__avail_o, id_alu1__avail_o); end
      tick();
      ckpt_rcov_i         = '0;
      alu0_id__inst_rdy_i = 1'b0;
      alu1_id__inst_rdy_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL rcov_all_vld: got %b want 0", id_alu__inst_vld_o); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b1) begin miscompares++; $display("FAIL rcov_all_rdy: got %b want 1", disp_rn__inst_rdy_o); end
      // Partial truncation: only the younger entry carries checkpoint 2.
      rn_disp__inst_i     = inst_h;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      rn_disp__inst_i = inst_i;
      tick();
      rn_disp__inst_vld_i = 1'b0;
      ckpt_rcov_i         = '{en: 1'b1, ckpt: 3'd2};
      tick();
      ckpt_rcov_i = '0;
      #1;
      vectors++; if (id_alu__inst_o !== inst_h || id_alu__inst_vld_o !== 1'b1) begin miscompares++; $display("FAIL rcov_part_head: got %h/%b want %h/1", id_alu__inst_o, id_alu__inst_vld_o, inst_h); end
      vectors++; if (disp_rn__inst_rdy_o !== 1'b1) begin miscompares++; $display("FAIL rcov_part_rdy: got %b want 1", disp_rn__inst_rdy_o); end
      // Recovery drops H while a push in the same cycle lands after the cut.
      ckpt_rcov_i         = '{en: 1'b1, ckpt: 3'd1};
      rn_disp__inst_i     = inst_j;
      rn_disp__inst_vld_i = 1'b1;
      tick();
      ckpt_rcov_i         = '0;
      rn_disp__inst_vld_i = 1'b0;
      #1;
      vectors++; if (id_alu__inst_o !== inst_j || id_alu__inst_vld_o !== 1'b1) begin miscompares++; $display("FAIL rcov_append: got %h/%b want %h/1", id_alu__inst_o, id_alu__inst_vld_o, inst_j); end
      alu0_id__inst_rdy_i = 1'b1;
      alu1_id__inst_rdy_i = 1'b1;
      tick();
      #1;
      vectors++; if (id_alu__inst_vld_o !== 1'b0) begin miscompares++; $display("FAIL rcov_append_count: got %b want 0", id_alu__inst_vld_o); end
      $display("test_ckpt_rcov done");
   endtask

   initial begin
      inst_a = mk(5, 0, 9, 1'b1, 0, 1);
      inst_b = mk(9, 0, 20, 1'b0, 0, 2);
      inst_c = mk(5, 6, 12, 1'b1, 0, 3);
      inst_e = mk(9, 12, 0, 1'b1, 0, 4);
      inst_f = mk(12, 0, 0, 1'b0, 0, 5);
      inst_g = mk(12, 9, 0, 1'b0, 0, 6);
      inst_h = mk(1, 2, 30, 1'b1, 1, 7);
      inst_i = mk(3, 4, 31, 1'b1, 2, 8);
      inst_j = mk(7, 8, 0, 1'b0, 4, 9);
      inst_k = mk(33, 34, 35, 1'b1, 0, 10);

      rst_i                = 1'b1;
      flush_en_i           = 1'b0;
      ckpt_rcov_i          = '0;
      id__prefet_ckpt_i    = 3'd3;
      rn_disp__inst_i      = '0;
      rn_disp__inst_vld_i  = 1'b0;
      alu0_id__inst_rdy_i  = 1'b1;
      alu1_id__inst_rdy_i  = 1'b1;
      alu0_id__left_size_i = 4'd4;
      alu1_id__left_size_i = 4'd6;
      alu0_iq__awake_i     = '0;
      alu1_iq__awake_i     = '0;
      mdu_iq__awake_i      = '0;
      lsu_iq__awake_i      = '0;

      test_reset();
      test_steer_pop();
      test_wakeup();
      test_steer_select();
      test_alloc_vs_awake();
      test_flush();
      test_ckpt_rcov();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
